// File: rtl/conv_pkg.sv
// conv_pkg: shared state encoding and counter-width helper for the convolution frame sequencer
package conv_pkg;
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;
  function automatic int cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/conv_tag_delay.sv
// conv_tag_delay: fixed-depth shift register of result tags with synchronous clear
module conv_tag_delay #(
  parameter int DEPTH = 2,
  parameter type T = logic
)(
  input  logic clk,
  input  logic clr,
  input  T     d,
  output T     q
);
  T sr [DEPTH];
  always_ff @(posedge clk) begin
    sr[0] <= clr ? '0 : d;
    for (int i = 1; i < DEPTH; i++) sr[i] <= clr ? '0 : sr[i-1];
  end
  assign q = sr[DEPTH-1];
endmodule

// File: rtl/conv_frame_sequencer.sv
// conv_frame_sequencer: frame sequencing, pixel feed and full-window result tagging for the 3x3 convolution engine
module conv_frame_sequencer
  import conv_pkg::*;
#(
  parameter int WORD_SIZE    = 8,
  parameter int ROW_SIZE     = 540,
  parameter int IMAGE_HEIGHT = 360,
  parameter int KERNEL_SIZE  = 3,
  parameter int CONV_LATENCY = 1
)(
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             abort,
  output logic                             busy,
  output logic                             done,
  input  logic [WORD_SIZE-1:0]             src_pixel,
  input  logic                             src_valid,
  output logic                             src_ready,
  output logic [WORD_SIZE-1:0]             conv_pixel,
  output logic                             conv_en,
  input  logic [WORD_SIZE-1:0]             conv_result,
  output logic [WORD_SIZE-1:0]             out_pixel,
  output logic                             out_valid,
  output logic [cnt_w(IMAGE_HEIGHT)-1:0]   out_row,
  output logic [cnt_w(ROW_SIZE)-1:0]       out_col
);
  localparam int ROW_W = cnt_w(IMAGE_HEIGHT);
  localparam int COL_W = cnt_w(ROW_SIZE);
  localparam int DW = cnt_w(CONV_LATENCY + 1);
  typedef struct packed {
    logic             win;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
  } tag_t;
  state_t state, state_n;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic [DW-1:0] dcnt;
  logic accept, last, row_end, clr;
  tag_t tag_in, tag_out;
  assign src_ready = state == STREAM;
  assign busy = state == STREAM || state == DRAIN;
  assign done = state == DONE;
  assign accept = src_valid & src_ready;
  assign row_end = col == COL_W'(ROW_SIZE - 1);
  assign last = accept && row_end && row == ROW_W'(IMAGE_HEIGHT - 1);
  assign clr = rst | abort;
  assign tag_in = '{
    win: accept && row >= ROW_W'(KERNEL_SIZE - 1) && col >= COL_W'(KERNEL_SIZE - 1),
    row: row - ROW_W'(KERNEL_SIZE - 1),
    col: col - COL_W'(KERNEL_SIZE - 1)
  };
  assign out_pixel = conv_result;
  assign out_valid = tag_out.win;
  assign out_row = tag_out.row;
  assign out_col = tag_out.col;
  conv_tag_delay #(.DEPTH(CONV_LATENCY + 1), .T(tag_t)) u_delay (
    .clk(clk),
    .clr(clr),
    .d(tag_in),
    .q(tag_out)
  );
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start && !abort ? STREAM : IDLE;
      STREAM:  state_n = abort ? IDLE : last ? DRAIN : STREAM;
      DRAIN:   state_n = abort ? IDLE : dcnt == '0 ? DONE : DRAIN;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      conv_en <= 1'b0;
      conv_pixel <= '0;
    end else begin
      state <= state_n;
      conv_en <= accept;
      if (accept) conv_pixel <= src_pixel;
    end
  end
  always_ff @(posedge clk) begin
    if (clr || last) begin
      row <= '0;
      col <= '0;
    end else if (accept) begin
      col <= row_end ? '0 : col + 1'b1;
      if (row_end) row <= row + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (clr) dcnt <= '0;
    else if (last) dcnt <= DW'(CONV_LATENCY);
    else if (state == DRAIN && dcnt != '0) dcnt <= dcnt - 1'b1;
  end
endmodule

// File: tb/tb_conv_frame_sequencer.sv
// tb_conv_frame_sequencer: directed frame scenarios checked every cycle against a raster-coordinate schedule model
module tb_conv_frame_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic abort = 1'b0;
  logic src_valid = 1'b0;
  logic [1:0] st = '0;
  logic [7:0] src_pixel = '0;
  logic [7:0] conv_result = '0;
  logic [1:0] busy, done, ready, en, ov;
  logic [7:0] cpix [2];
  logic [7:0] opix [2];
  logic [1:0] orow [2];
  logic [2:0] ocol [2];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int lat [2] = '{1, 3};
  int mode [2] = '{0, 0};
  int npix [2] = '{0, 0};
  int done_cyc [2] = '{0, 0};
  int acc12 [2] = '{0, 0};
  int first00 [2] = '{0, 0};
  int exp_pix [2] = '{0, 0};
  int cnt_ov [2] = '{0, 0};
  int cnt_dn [2] = '{0, 0};
  int cnt_en [2] = '{0, 0};
  int exp_coords [6] = '{0, 1, 2, 8, 9, 10};
  int exp_tag [int];
  int exp_en [int];
  int q0 [$];
  int q1 [$];

  always #5 clk = ~clk;

  conv_frame_sequencer #(.WORD_SIZE(8), .ROW_SIZE(5), .IMAGE_HEIGHT(4), .KERNEL_SIZE(3), .CONV_LATENCY(1)) dut (
    .clk(clk), .rst(rst), .start(st[0]), .abort(abort), .busy(busy[0]), .done(done[0]),
    .src_pixel(src_pixel), .src_valid(src_valid), .src_ready(ready[0]), .conv_pixel(cpix[0]),
    .conv_en(en[0]), .conv_result(conv_result), .out_pixel(opix[0]), .out_valid(ov[0]),
    .out_row(orow[0]), .out_col(ocol[0])
  );

  conv_frame_sequencer #(.WORD_SIZE(8), .ROW_SIZE(5), .IMAGE_HEIGHT(4), .KERNEL_SIZE(3), .CONV_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .start(st[1]), .abort(abort), .busy(busy[1]), .done(done[1]),
    .src_pixel(src_pixel), .src_valid(src_valid), .src_ready(ready[1]), .conv_pixel(cpix[1]),
    .conv_en(en[1]), .conv_result(conv_result), .out_pixel(opix[1]), .out_valid(ov[1]),
    .out_row(orow[1]), .out_col(ocol[1])
  );

  function automatic int key(input int d, input int c);
    return d * 1000000 + c;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic purge(input int d);
    for (int j = 1; j <= 6; j++) begin
      exp_tag.delete(key(d, cyc + j));
      exp_en.delete(key(d, cyc + j));
    end
  endtask

  task automatic observe();
    int k, rr, cc;
    for (int d = 0; d < 2; d++) begin
      k = key(d, cyc);
      chk("out_valid", int'(ov[d]), int'(exp_tag.exists(k)));
      if (exp_tag.exists(k) && ov[d]) chk("out_coord", int'(orow[d]) * 8 + int'(ocol[d]), exp_tag[k]);
      chk("conv_en", int'(en[d]), int'(exp_en.exists(k)));
      if (exp_en.exists(k)) exp_pix[d] = exp_en[k];
      chk("conv_pixel", int'(cpix[d]), exp_pix[d]);
      chk("src_ready", int'(ready[d]), int'(mode[d] == 1));
      chk("busy", int'(busy[d]), int'(mode[d] == 1 || (mode[d] == 2 && cyc < done_cyc[d])));
      chk("done", int'(done[d]), int'(mode[d] == 2 && cyc == done_cyc[d]));
      chk("out_pixel", int'(opix[d]), int'(conv_result));
      cnt_ov[d] += int'(ov[d]);
      cnt_dn[d] += int'(done[d]);
      cnt_en[d] += int'(en[d]);
      if (ov[d]) begin
        if (d == 1) q1.push_back(int'(orow[d]) * 8 + int'(ocol[d]));
        else q0.push_back(int'(orow[d]) * 8 + int'(ocol[d]));
        if (orow[d] == 0 && ocol[d] == 0) first00[d] = cyc;
      end
      if (rst) begin
        mode[d] = 0;
        npix[d] = 0;
        exp_pix[d] = 0;
        purge(d);
      end else if (mode[d] == 0) begin
        if (st[d] && !abort) begin
          mode[d] = 1;
          npix[d] = 0;
        end
      end else if (abort && !(mode[d] == 2 && cyc == done_cyc[d])) begin
        mode[d] = 0;
        npix[d] = 0;
        purge(d);
      end else if (mode[d] == 1) begin
        if (src_valid) begin
          exp_en[key(d, cyc + 1)] = int'(src_pixel);
          rr = npix[d] / 5;
          cc = npix[d] % 5;
          if (rr >= 2 && cc >= 2) exp_tag[key(d, cyc + 1 + lat[d])] = (rr - 2) * 8 + (cc - 2);
          if (npix[d] == 12) acc12[d] = cyc;
          npix[d]++;
          if (npix[d] == 20) begin
            mode[d] = 2;
            done_cyc[d] = cyc + lat[d] + 2;
          end
        end
      end else if (mode[d] == 2 && cyc == done_cyc[d]) begin
        mode[d] = 0;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
    cyc++;
    conv_result = 8'(cyc * 37 + 11);
  endtask

  task automatic pulse_start(input int d);
    st[d] = 1'b1;
    step();
    st[d] = 1'b0;
  endtask

  task automatic stream(input int d, input bit gaps, input int stop, input bit mid);
    int p, k;
    bit v, r;
    p = 0;
    k = 0;
    while (p < stop && k < 200) begin
      v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      src_valid = v;
      src_pixel = 8'(p);
      st[d] = mid && p == 5;
      r = ready[d];
      step();
      if (v && r) p++;
      k++;
    end
    src_valid = 1'b0;
    st[d] = 1'b0;
    chk("stream_progress", p, stop);
  endtask

  task automatic wait_done(input int d, input bit mid);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      st[d] = mid && i == 0;
      step();
      st[d] = 1'b0;
      ok = done[d];
    end
    chk("done_seen", int'(ok), 1);
    step();
  endtask

  task automatic run_frame(input int d, input bit gaps, input bit mid);
    int ov0, dn0, en0, qs;
    ov0 = cnt_ov[d];
    dn0 = cnt_dn[d];
    en0 = cnt_en[d];
    qs = d == 1 ? q1.size() : q0.size();
    pulse_start(d);
    stream(d, gaps, 20, mid);
    wait_done(d, mid);
    chk("frame_outputs", cnt_ov[d] - ov0, 6);
    chk("frame_done_pulses", cnt_dn[d] - dn0, 1);
    chk("frame_conv_en", cnt_en[d] - en0, 20);
    chk("first_out_latency", first00[d] - acc12[d], d == 1 ? 4 : 2);
    for (int i = 0; i < 6; i++) chk("raster_coord", d == 1 ? q1[qs + i] : q0[qs + i], exp_coords[i]);
  endtask

  initial begin
    int ov0, dn0;
    step();
    step();
    rst = 1'b0;
    step();
    run_frame(0, 1'b0, 1'b0);
    run_frame(0, 1'b1, 1'b0);
    run_frame(0, 1'b0, 1'b1);
    ov0 = cnt_ov[0];
    dn0 = cnt_dn[0];
    pulse_start(0);
    stream(0, 1'b0, 14, 1'b0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_busy", int'(busy[0]), 0);
    chk("abort_ready", int'(ready[0]), 0);
    for (int i = 0; i < 6; i++) step();
    chk("abort_outputs", cnt_ov[0] - ov0, 1);
    chk("abort_done", cnt_dn[0] - dn0, 0);
    run_frame(0, 1'b0, 1'b0);
    pulse_start(0);
    stream(0, 1'b0, 9, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_busy", int'(busy[0]), 0);
    chk("rst_ready", int'(ready[0]), 0);
    chk("rst_conv_en", int'(en[0]), 0);
    chk("rst_conv_pixel", int'(cpix[0]), 0);
    chk("rst_out_valid", int'(ov[0]), 0);
    chk("rst_out_row", int'(orow[0]), 0);
    chk("rst_out_col", int'(ocol[0]), 0);
    step();
    run_frame(0, 1'b0, 1'b0);
    dn0 = cnt_dn[1];
    ov0 = cnt_ov[1];
    run_frame(1, 1'b0, 1'b0);
    run_frame(1, 1'b0, 1'b0);
    chk("lat3_total_outputs", cnt_ov[1] - ov0, 12);
    chk("lat3_total_done", cnt_dn[1] - dn0, 2);
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
